// File: rtl/alu_share_arbiter_if.sv
// Handshake and operand bus between two requesters, the shared ALU and the arbiter.
// The arbiter connects through the slave modport. The requester/ALU side uses the master modport.
interface alu_share_arbiter_if;
  logic        ReqA;
  logic        ReqB;
  logic [31:0] InA_A;
  logic [31:0] InB_A;
  logic [31:0] InA_B;
  logic [31:0] InB_B;
  logic [3:0]  CtlA;
  logic [3:0]  CtlB;
  logic [31:0] ALUA;
  logic [31:0] ALUB;
  logic [3:0]  ALUControl;
  logic [31:0] ALUResult;
  logic        GntA;
  logic        GntB;
  logic        DoneA;
  logic        DoneB;
  logic [31:0] Result;
  logic        Busy;

  modport master (
    output ReqA, ReqB, InA_A, InB_A, InA_B, InB_B, CtlA, CtlB, ALUResult,
    input  ALUA, ALUB, ALUControl, GntA, GntB, DoneA, DoneB, Result, Busy
  );

  modport slave (
    input  ReqA, ReqB, InA_A, InB_A, InA_B, InB_B, CtlA, CtlB, ALUResult,
    output ALUA, ALUB, ALUControl, GntA, GntB, DoneA, DoneB, Result, Busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Arbitrates two requesters onto one combinational ALU. Arbitration is round-robin, or fixed-priority A when ALU_ARB_FIXED_PRIO_EN is defined.
// Done arrives 2 cycles after Req is sampled, or MUL_CYCLES+1 cycles for a mul. Each Req is a level that is held until its Done, and a loser waits.
module alu_share_arbiter #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  alu_share_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
  localparam logic [3:0] CTL_MUL  = 4'd8;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  op_ctl;
  logic [3:0]  cnt;
  logic [31:0] result;
  logic        win_b;
  logic        pick_b;
  logic        any_req;
  logic [3:0]  sel_ctl;

  assign any_req = bus.ReqA | bus.ReqB;
  assign sel_ctl = pick_b ? bus.CtlB : bus.CtlA;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign pick_b = bus.ReqB & ~bus.ReqA;
`else
  // last_b set means B was granted last, so A wins the next tie.
  logic last_b;

  assign pick_b = bus.ReqB & (~bus.ReqA | ~last_b);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_b <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_b <= pick_b;
    end
  end
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.ALUA       = 32'd0;
    bus.ALUB       = 32'd0;
    bus.ALUControl = 4'd0;
    bus.GntA       = 1'b0;
    bus.GntB       = 1'b0;
    bus.DoneA      = 1'b0;
    bus.DoneB      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = EXEC;
      end
      EXEC: begin
        bus.ALUA       = op_a;
        bus.ALUB       = op_b;
        bus.ALUControl = op_ctl;
        bus.GntA       = ~win_b;
        bus.GntB       = win_b;
        if (cnt == 4'd1) state_nxt = DONE;
      end
      DONE: begin
        bus.GntA  = ~win_b;
        bus.GntB  = win_b;
        bus.DoneA = ~win_b;
        bus.DoneB = win_b;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      op_a   <= 32'd0;
      op_b   <= 32'd0;
      op_ctl <= 4'd0;
      cnt    <= 4'd0;
      win_b  <= 1'b0;
      result <= 32'd0;
    end else begin
      if (state == IDLE && any_req) begin
        win_b  <= pick_b;
        op_a   <= pick_b ? bus.InA_B : bus.InA_A;
        op_b   <= pick_b ? bus.InB_B : bus.InB_A;
        op_ctl <= sel_ctl;
        cnt    <= (sel_ctl == CTL_MUL) ? MUL_LOAD : 4'd1;
      end else if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) result <= bus.ALUResult;
      end
    end
  end

  assign bus.Result = result;
  assign bus.Busy   = (state != IDLE);

endmodule
